gf2_poly_divider: RTL
=====================

GF2_POLY_DIVIDER -- requirements
Module: gf2_poly_divider

Interface
REQ-001 The module SHALL have no parameters; widths are fixed at 163-bit dividend, 82-bit divisor, 82-bit quotient and 81-bit remainder.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  163  dividend polynomial over GF(2); bit i is the coefficient of x^i.
REQ-006 b  input  82  divisor polynomial; b[81] must be 1.
REQ-007 busy  output  1  high while an operation is in progress (RUN state).
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 err  output  1  high when the last operation had b[81]==0; held until the next accepted start.
REQ-010 q  output  82  quotient floor(a/b) over GF(2).
REQ-011 r  output  81  remainder a mod b; degree <= 80.

Function
REQ-012 The module SHALL perform carry-less long division with a = q*b XOR r (carry-less product), so that a 163-bit product from the 82x82 Karatsuba multiplier divides back exactly.
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIN; FIN always returns to IDLE after one cycle.
REQ-014 In IDLE, start=1 SHALL capture a and b into internal registers, clear q, r and err, and go to RUN, or to FIN when b[81]==0.
REQ-015 A start asserted in RUN or FIN SHALL be ignored, with no effect on state, operands or outputs.
REQ-016 Each RUN cycle SHALL process the current top dividend bit, from x^162 down to x^81: if it is 1, XOR b<<k into the working remainder and set quotient bit k; then decrement k.
REQ-017 A 7-bit step counter SHALL load 81 on start, and RUN SHALL exit to FIN after the step with k==0, for exactly 82 RUN cycles in total.
REQ-018 done SHALL be high for exactly the FIN cycle; q and r SHALL update on entry to FIN and hold until the next accepted start.
REQ-019 Latency from the start-sampling edge to the first cycle with done=1 SHALL be 83 cycles (single-bit mode) and 1 cycle on the err path.
REQ-020 On the err path, q and r SHALL be 0 and err SHALL be 1 during done.
REQ-021 busy SHALL be 1 exactly in RUN; busy and done SHALL never both be 1.
REQ-022 start asserted in the FIN cycle SHALL be ignored; a new operation may start on the next IDLE cycle.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, counter=0, busy=0, done=0, err=0, q=0, r=0 and clear the operand registers.
REQ-024 Reset asserted mid-operation SHALL abort it, with no done pulse issued for the aborted operation.
REQ-025 The first accepted start SHALL be the first rising clk edge with rst_n high and start high.

Configuration
REQ-026 With GF2_DIV_RADIX4_EN defined, each RUN cycle SHALL retire two quotient bits: the counter loads 40 and RUN lasts 41 cycles, giving a done latency of 42.
REQ-027 Without GF2_DIV_RADIX4_EN, the block SHALL retire one bit per cycle as in REQ-016 to REQ-019.
REQ-028 Results SHALL be bit-identical in both modes.

Structure
REQ-029 Package gf2_pkg SHALL hold localparams GF2_N=82, GF2_PROD_W=163, GF2_REM_W=81 and the FSM state enum typedef.
REQ-030 Sub-module gf2_div_step SHALL be combinational, taking the working remainder, b and the step index and returning the next remainder and a quotient bit; it is instantiated once, or twice chained under GF2_DIV_RADIX4_EN.

Verification
REQ-031 a=1<<162, b=1<<81 -> done at cycle 83, q=1<<81, r=0, err=0.
REQ-032 a=0, b=(1<<81)|1 -> q=0, r=0 after the full latency; busy high for 82 cycles.
REQ-033 Random q (82-bit), random b with b[81]=1, random r (81-bit); a = karatsuba_82x82(q,b)[162:0] XOR r -> outputs recover exactly q and r over 10k vectors, in both macro settings.
REQ-034 b=82'h1 (b[81]=0) -> done one cycle after start, err=1, q=0, r=0; the next valid start clears err.
REQ-035 start re-pulsed at cycles 10 and 50 of a RUN -> ignored; a single done pulse with correct results.
REQ-036 rst_n low at RUN cycle 40 -> immediate IDLE with all outputs 0 and no done; the subsequent operation completes correctly.

Source files
------------

// File: rtl/gf2_pkg.sv
// Shared widths and FSM state encoding for the GF(2) polynomial divider.
package gf2_pkg;
  localparam int unsigned GF2_N      = 82;
  localparam int unsigned GF2_PROD_W = 163;
  localparam int unsigned GF2_REM_W  = 81;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;
endpackage

// File: rtl/gf2_div_step.sv
// One carry-less long-division step: clears dividend bit x^(81+k) by
// XORing in b<<k when that bit is set, and reports the quotient bit.
module gf2_div_step
  import gf2_pkg::*;
(
  input  logic [GF2_PROD_W-1:0] rem,
  input  logic [GF2_N-1:0]      b,
  input  logic [6:0]            k,
  output logic [GF2_PROD_W-1:0] rem_next,
  output logic                  qbit
);
  logic [7:0] top;

  assign top      = 8'(GF2_REM_W) + {1'b0, k};
  assign qbit     = rem[top];
  assign rem_next = qbit ? (rem ^ ({{GF2_REM_W{1'b0}}, b} << k)) : rem;
endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2) polynomial divider: a = q*b XOR r, one quotient bit per
// RUN cycle, or two per cycle when GF2_DIV_RADIX4_EN is defined.
module gf2_poly_divider
  import gf2_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [GF2_PROD_W-1:0] a,
  input  logic [GF2_N-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [GF2_N-1:0]      q,
  output logic [GF2_REM_W-1:0]  r
);
  state_t                state;
  logic [6:0]            cnt;
  logic [GF2_PROD_W-1:0] w;
  logic [GF2_N-1:0]      b_reg;
  logic [GF2_N-1:0]      q_acc;
  logic [GF2_PROD_W-1:0] w_next;
  logic [GF2_N-1:0]      q_next;

`ifdef GF2_DIV_RADIX4_EN
  localparam logic [6:0] CNT_LOAD = 7'd40;

  logic [6:0]            k_hi;
  logic [6:0]            k_lo;
  logic [GF2_PROD_W-1:0] w_mid;
  logic                  qbit_hi;
  logic                  qbit_lo;

  // Counter c covers quotient bits 2c+1 and 2c; the high bit is resolved first.
  assign k_hi = (cnt << 1) | 7'd1;
  assign k_lo = cnt << 1;

  gf2_div_step u_step_hi (
    .rem      (w),
    .b        (b_reg),
    .k        (k_hi),
    .rem_next (w_mid),
    .qbit     (qbit_hi)
  );

  gf2_div_step u_step_lo (
    .rem      (w_mid),
    .b        (b_reg),
    .k        (k_lo),
    .rem_next (w_next),
    .qbit     (qbit_lo)
  );

  always_comb begin
    q_next       = q_acc;
    q_next[k_hi] = qbit_hi;
    q_next[k_lo] = qbit_lo;
  end
`else
  localparam logic [6:0] CNT_LOAD = 7'd81;

  logic qbit;

  gf2_div_step u_step (
    .rem      (w),
    .b        (b_reg),
    .k        (cnt),
    .rem_next (w_next),
    .qbit     (qbit)
  );

  always_comb begin
    q_next      = q_acc;
    q_next[cnt] = qbit;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      w     <= '0;
      b_reg <= '0;
      q_acc <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      q     <= '0;
      r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w     <= a;
            b_reg <= b;
            q_acc <= '0;
            q     <= '0;
            r     <= '0;
            cnt   <= CNT_LOAD;
            err   <= ~b[GF2_N-1];
            if (b[GF2_N-1]) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          w     <= w_next;
          q_acc <= q_next;
          if (cnt == 7'd0) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            q     <= q_next;
            r     <= w_next[GF2_REM_W-1:0];
          end else begin
            cnt <= cnt - 7'd1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
